gunshot_event_qualifier: RTL and testbench



---
 rtl/gunshot_pkg.sv | 16 +
 rtl/gunshot_event_qualifier_if.sv | 21 ++
 rtl/gunshot_ts_counter.sv | 17 +
 rtl/gunshot_event_qualifier.sv | 129 ++++++++++++
 tb/tb_gunshot_event_qualifier.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/gunshot_pkg.sv
// Shared types for the gunshot event qualifier: FSM state and kernel_size codes.
package gunshot_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMING  = 2'd1,
        S_REPORT  = 2'd2,
        S_HOLDOFF = 2'd3
    } gs_state_e;

    localparam logic [1:0] KSIZE_3x3     = 2'b00;
    localparam logic [1:0] KSIZE_5x5     = 2'b01;
    localparam logic [1:0] KSIZE_7x7     = 2'b10;
    localparam logic [1:0] KSIZE_INVALID = 2'b11;

endpackage

// File: rtl/gunshot_event_qualifier_if.sv
// Event handshake from the qualifier to the direction/report logic.
interface gunshot_event_qualifier_if #(
    parameter int TS_W   = 16,
    parameter int SPAN_W = 8
);
    logic              event_valid;
    logic              event_ready;
    logic [TS_W-1:0]   event_timestamp;
    logic [SPAN_W-1:0] event_span;
    logic [1:0]        event_kernel;

    modport master (
        output event_valid, event_timestamp, event_span, event_kernel,
        input  event_ready
    );

    modport slave (
        input  event_valid, event_timestamp, event_span, event_kernel,
        output event_ready
    );
endinterface

// File: rtl/gunshot_ts_counter.sv
// Free-running wrap-around timestamp; never stalled.
module gunshot_ts_counter #(
    parameter int TS_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic [TS_W-1:0] ts_o
);
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign ts_o = ts_q;
endmodule

// File: rtl/gunshot_event_qualifier.sv
// Turns per-cycle CNN hits into qualified, timestamped gunshot events with
// gap tolerance, a valid/ready report and an echo-suppressing hold-off.
module gunshot_event_qualifier
    import gunshot_pkg::*;
#(
    parameter int TS_W        = 16,
    parameter int SPAN_W      = 8,
    parameter int MIN_HITS    = 3,
    parameter int MAX_GAP     = 2,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       detected,
    input  logic [1:0] kernel_size,
    output logic       busy,
    gunshot_event_qualifier_if.master ev
);
    localparam int HIT_W  = $clog2(MIN_HITS + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 2);
    localparam int HOLD_W = (HOLDOFF_CYC < 1) ? 1 : $clog2(HOLDOFF_CYC + 1);

    localparam logic [HIT_W-1:0]  MIN_HITS_L = HIT_W'(MIN_HITS);
    localparam logic [GAP_W-1:0]  MAX_GAP_L  = GAP_W'(MAX_GAP);
    localparam logic [HOLD_W-1:0] HOLD_L     = HOLD_W'(HOLDOFF_CYC);

    logic [TS_W-1:0]   ts;
    gs_state_e         state_q;
    logic [TS_W-1:0]   start_ts_q;
    logic [1:0]        kern_q;
    logic [HIT_W-1:0]  hits_q;
    logic [GAP_W-1:0]  gap_q;
    logic [SPAN_W-1:0] span_q;
    logic [HOLD_W-1:0] hold_q;
    logic              valid_q;
    logic [TS_W-1:0]   ev_ts_q;
    logic [SPAN_W-1:0] ev_span_q;
    logic [1:0]        ev_kern_q;
    logic [SPAN_W-1:0] span_inc;

    gunshot_ts_counter #(.TS_W(TS_W)) u_ts (
        .clk   (clk),
        .reset (reset),
        .ts_o  (ts)
    );

    assign span_inc = (span_q == '1) ? span_q : span_q + SPAN_W'(1);

    // Payload registers are only loaded on entry to REPORT, so they stay
    // stable for the whole valid&&!ready window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_ts_q <= '0;
            kern_q     <= '0;
            hits_q     <= '0;
            gap_q      <= '0;
            span_q     <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            ev_ts_q    <= '0;
            ev_span_q  <= '0;
            ev_kern_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (detected && kernel_size != KSIZE_INVALID) begin
                        start_ts_q <= ts;
                        kern_q     <= kernel_size;
                        hits_q     <= HIT_W'(1);
                        gap_q      <= '0;
                        span_q     <= '0;
                        if (MIN_HITS == 1) begin
                            state_q   <= S_REPORT;
                            valid_q   <= 1'b1;
                            ev_ts_q   <= ts;
                            ev_span_q <= '0;
                            ev_kern_q <= kernel_size;
                        end else begin
                            state_q <= S_ARMING;
                        end
                    end
                end
                S_ARMING: begin
                    span_q <= span_inc;
                    // A kernel change kills the burst even if this cycle is a hit.
                    if (kernel_size != kern_q) begin
                        state_q <= S_IDLE;
                    end else if (detected) begin
                        hits_q <= hits_q + HIT_W'(1);
                        gap_q  <= '0;
                        if (hits_q + HIT_W'(1) == MIN_HITS_L) begin
                            state_q   <= S_REPORT;
                            valid_q   <= 1'b1;
                            ev_ts_q   <= start_ts_q;
                            ev_span_q <= span_inc;
                            ev_kern_q <= kern_q;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                        if (gap_q + GAP_W'(1) > MAX_GAP_L) state_q <= S_IDLE;
                    end
                end
                S_REPORT: begin
                    if (ev.event_ready) begin
                        valid_q <= 1'b0;
                        if (HOLDOFF_CYC == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_HOLDOFF;
                            hold_q  <= HOLD_L;
                        end
                    end
                end
                S_HOLDOFF: begin
                    hold_q <= hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign ev.event_valid     = valid_q;
    assign ev.event_timestamp = ev_ts_q;
    assign ev.event_span      = ev_span_q;
    assign ev.event_kernel    = ev_kern_q;
endmodule

// File: tb/tb_gunshot_event_qualifier.sv
// Directed vector table plus randomized run against a cycle-number based reference model.
module tb_gunshot_event_qualifier;
    localparam int TS_W     = 16;
    localparam int SPAN_W   = 8;
    localparam int MIN_HITS = 3;
    localparam int MAX_GAP  = 2;
    localparam int HOLD     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       detected = 1'b0;
    logic [1:0] kernel_size = 2'b00;
    logic       busy;

    gunshot_event_qualifier_if #(.TS_W(TS_W), .SPAN_W(SPAN_W)) ev_if ();

    gunshot_event_qualifier #(
        .TS_W(TS_W), .SPAN_W(SPAN_W), .MIN_HITS(MIN_HITS),
        .MAX_GAP(MAX_GAP), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .detected    (detected),
        .kernel_size (kernel_size),
        .busy        (busy),
        .ev          (ev_if)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int n_acc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: works in absolute edge numbers (edge 0 = first edge after reset).
    int         m_e, m_free_at, m_start, m_last, m_hits, m_ts, m_span;
    bit         m_burst, m_pend;
    logic [1:0] m_kern;

    task automatic model_reset();
        m_e = 0; m_free_at = 0; m_start = 0; m_last = 0; m_hits = 0;
        m_ts = 0; m_span = 0; m_burst = 0; m_pend = 0; m_kern = 0;
    endtask

    task automatic model_qualify();
        int sp;
        m_pend  = 1;
        m_burst = 0;
        m_ts    = m_start % (1 << TS_W);
        sp      = m_e - m_start;
        m_span  = (sp > (1 << SPAN_W) - 1) ? (1 << SPAN_W) - 1 : sp;
    endtask

    task automatic model_step(input bit det, input logic [1:0] ks, input bit rdy);
        if (m_pend) begin
            if (rdy) begin
                m_pend    = 0;
                m_free_at = m_e + HOLD + 1;
            end
        end else if (m_e < m_free_at) begin
            // echo suppression window: hits ignored
        end else if (m_burst) begin
            if (ks != m_kern) m_burst = 0;
            else if (det) begin
                m_hits++;
                m_last = m_e;
                if (m_hits == MIN_HITS) model_qualify();
            end else if (m_e - m_last > MAX_GAP) m_burst = 0;
        end else if (det && ks != 2'b11) begin
            m_burst = 1; m_start = m_e; m_last = m_e; m_hits = 1; m_kern = ks;
            if (m_hits == MIN_HITS) model_qualify();
        end
        m_e++;
    endtask

    task automatic tick();
        if (ev_if.event_valid && ev_if.event_ready) n_acc++;
        @(posedge clk);
        model_step(detected, kernel_size, ev_if.event_ready);
        #1;
        chk("m_valid", ev_if.event_valid, m_pend);
        chk("m_busy", busy, m_burst || m_pend || (m_e < m_free_at));
        if (m_pend) begin
            chk("m_ts", ev_if.event_timestamp, m_ts);
            chk("m_span", ev_if.event_span, m_span);
            chk("m_kern", ev_if.event_kernel, m_kern);
        end
    endtask

    typedef struct {
        bit         det;
        logic [1:0] ks;
        bit         rdy;
        int         n;
        bit         ev;
        bit         eb;
        int         ets;
        int         esp;
        logic [1:0] ek;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(bit d, logic [1:0] k, bit r, int n, bit v, bit b,
                               int ts = 0, int sp = 0, logic [1:0] kk = 2'b00);
        vec_t x;
        x.det = d; x.ks = k; x.rdy = r; x.n = n; x.ev = v; x.eb = b;
        x.ets = ts; x.esp = sp; x.ek = kk;
        return x;
    endfunction

    task automatic run_vec(input vec_t x, input int idx);
        detected = x.det; kernel_size = x.ks; ev_if.event_ready = x.rdy;
        repeat (x.n) tick();
        chk($sformatf("v%0d_valid", idx), ev_if.event_valid, x.ev);
        chk($sformatf("v%0d_busy", idx), busy, x.eb);
        if (x.ev) begin
            chk($sformatf("v%0d_ts", idx), ev_if.event_timestamp, x.ets);
            chk($sformatf("v%0d_span", idx), ev_if.event_span, x.esp);
            chk($sformatf("v%0d_kern", idx), ev_if.event_kernel, x.ek);
        end
    endtask

    initial begin
        int acc0;
        ev_if.event_ready = 1'b1;
        #12;
        chk("rst_valid", ev_if.event_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ts", ev_if.event_timestamp, 0);
        chk("rst_span", ev_if.event_span, 0);
        chk("rst_kern", ev_if.event_kernel, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Comments give the edge numbers each record covers.
        vecs.push_back(V(0, 0, 1, 10, 0, 0));             // 0-9 idle
        vecs.push_back(V(1, 0, 1, 2, 0, 1));              // 10,11
        vecs.push_back(V(1, 0, 1, 1, 1, 1, 10, 2, 0));    // 12 qualify
        vecs.push_back(V(1, 0, 1, 1, 0, 1));              // 13 accept
        vecs.push_back(V(1, 0, 1, 15, 0, 1));             // 14-28 hold-off
        vecs.push_back(V(0, 0, 1, 1, 0, 0));              // 29 idle
        vecs.push_back(V(1, 0, 1, 1, 0, 1));              // 30
        vecs.push_back(V(0, 0, 1, 2, 0, 1));              // 31,32 gap
        vecs.push_back(V(1, 0, 1, 1, 0, 1));              // 33
        vecs.push_back(V(1, 0, 1, 1, 1, 1, 30, 4, 0));    // 34 qualify
        vecs.push_back(V(0, 0, 1, 1, 0, 1));              // 35 accept
        vecs.push_back(V(0, 0, 1, 15, 0, 1));             // 36-50
        vecs.push_back(V(0, 0, 1, 1, 0, 0));              // 51
        vecs.push_back(V(1, 0, 1, 1, 0, 1));              // 52
        vecs.push_back(V(0, 0, 1, 2, 0, 1));              // 53,54
        vecs.push_back(V(0, 0, 1, 1, 0, 0));              // 55 third miss drops burst
        vecs.push_back(V(1, 2, 0, 2, 0, 1));              // 56,57
        vecs.push_back(V(1, 2, 0, 1, 1, 1, 56, 2, 2));    // 58 qualify, stalled
        vecs.push_back(V(1, 2, 0, 5, 1, 1, 56, 2, 2));    // 59-63 held
        vecs.push_back(V(1, 2, 1, 1, 0, 1));              // 64 accept
        vecs.push_back(V(0, 0, 1, 15, 0, 1));             // 65-79
        vecs.push_back(V(0, 0, 1, 1, 0, 0));              // 80
        vecs.push_back(V(1, 0, 1, 2, 0, 1));              // 81,82
        vecs.push_back(V(1, 1, 1, 1, 0, 0));              // 83 kernel change aborts
        vecs.push_back(V(1, 3, 1, 3, 0, 0));              // 84-86 invalid kernel
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Continuous hits for 60 cycles: starts at 87,107,127.
        acc0 = n_acc;
        run_vec(V(1, 0, 1, 60, 0, 0), 100);
        chk("cont_events", n_acc - acc0, 3);
        run_vec(V(0, 0, 1, 2, 0, 0), 101);

        // Asynchronous reset while an event is pending.
        detected = 1'b1; kernel_size = 2'b00; ev_if.event_ready = 1'b0;
        repeat (3) tick();
        chk("pre_rst_valid", ev_if.event_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", ev_if.event_valid, 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        detected = 1'b1; kernel_size = 2'b01; ev_if.event_ready = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", ev_if.event_valid, 1);
        chk("post_rst_ts", ev_if.event_timestamp, 0);
        chk("post_rst_span", ev_if.event_span, 2);
        chk("post_rst_kern", ev_if.event_kernel, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            detected = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 31) == 0) kernel_size = 2'($urandom_range(0, 3));
            ev_if.event_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
